ref_period_tracker: RTL and testbench

//   Measures the period of an external reference square wave in clk_in cycles and

---
 rtl/ref_period_tracker.sv | 141 ++++++++++++++
 tb/tb_ref_period_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ref_period_tracker.sv
// Reference period tracker: measures ref_in period in clk_in cycles, drives freq_param/lock/loss flags.
// Define PERIOD_FILTER_EN to smooth freq_param with a 1/2^FILT_SHIFT IIR filter.
module ref_period_tracker #(
  parameter int CNT_W         = 16,
  parameter int FILT_SHIFT    = 2,
  parameter int LOCK_TOL      = 2,
  parameter int LOCK_CNT      = 4,
  parameter int DEFAULT_PARAM = 100
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       ref_in,
  output logic [7:0] freq_param,
  output logic       freq_valid,
  output logic       locked,
  output logic       no_ref
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CLAMP   = CNT_W'(255);

  if (CNT_W < 8 || FILT_SHIFT < 1 || LOCK_CNT < 1) begin : g_param_check
    $error("ref_period_tracker: need CNT_W >= 8, FILT_SHIFT >= 1, LOCK_CNT >= 1");
  end

  typedef enum logic {ACQUIRE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sync1, sync2, sync3, edge_p;
  logic             meas, timeout;
  logic [7:0]       c, diff, fp_upd;
  logic             in_tol;
  logic [LW-1:0]    lock_cnt;

  // Two-flop synchronizer, then a registered rising-edge pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync1  <= ref_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_p <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= ACQUIRE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    meas      = 1'b0;
    timeout   = 1'b0;
    case (state)
      ACQUIRE: begin
        cnt_nxt = '0;
        if (edge_p) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEASURE: begin
        // An edge coinciding with saturation still counts as a measurement.
        if (edge_p) begin
          meas    = 1'b1;
          cnt_nxt = CNT_W'(1);
        end else if (cnt == CNT_MAX) begin
          timeout   = 1'b1;
          state_nxt = ACQUIRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ACQUIRE;
    endcase
  end

  assign c      = (cnt > CLAMP) ? 8'hFF : cnt[7:0];
  assign diff   = (c >= freq_param) ? (c - freq_param) : (freq_param - c);
  assign in_tol = (int'(diff) <= LOCK_TOL);

`ifdef PERIOD_FILTER_EN
  localparam int ACC_W = 8 + FILT_SHIFT;
  logic [ACC_W-1:0] acc, acc_nxt;

  assign acc_nxt = no_ref ? (ACC_W'(c) << FILT_SHIFT)
                          : (acc + ACC_W'(c) - (acc >> FILT_SHIFT));
  assign fp_upd  = 8'(acc_nxt >> FILT_SHIFT);

  always_ff @(posedge clk_in) begin
    if (rst)       acc <= '0;
    else if (meas) acc <= acc_nxt;
  end
`else
  assign fp_upd = c;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      freq_param <= 8'(DEFAULT_PARAM);
      freq_valid <= 1'b0;
      locked     <= 1'b0;
      no_ref     <= 1'b1;
      lock_cnt   <= '0;
    end else begin
      freq_valid <= meas;
      if (timeout) begin
        no_ref   <= 1'b1;
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (meas) begin
        freq_param <= fp_upd;
        if (no_ref) begin
          no_ref   <= 1'b0;
          lock_cnt <= '0;
        end else if (in_tol) begin
          if (lock_cnt != LW'(LOCK_CNT)) lock_cnt <= lock_cnt + LW'(1);
          if (lock_cnt >= LW'(LOCK_CNT - 1)) locked <= 1'b1;
        end else begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ref_period_tracker.sv
// Randomized bench for ref_period_tracker: a 16-bit and an 8-bit counter instance share one
// reference and are compared every cycle against a timestamp-based reference model.
module tb_ref_period_tracker;

  localparam int DEF  = 100;
  localparam int TOL  = 2;
  localparam int LCNT = 4;
  localparam int K    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rin = 1'b0;
  logic [7:0] fp_l, fp_s;
  logic       fv_l, fv_s, lk_l, lk_s, nr_l, nr_s;

  always #5 clk = ~clk;

  ref_period_tracker #(.CNT_W(16)) u_long (
    .clk_in(clk), .rst(rst), .ref_in(rin),
    .freq_param(fp_l), .freq_valid(fv_l), .locked(lk_l), .no_ref(nr_l)
  );

  ref_period_tracker #(.CNT_W(8)) u_short (
    .clk_in(clk), .rst(rst), .ref_in(rin),
    .freq_param(fp_s), .freq_valid(fv_s), .locked(lk_s), .no_ref(nr_s)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ref_in rises are timestamped; a rise sampled at cycle k acts at k+3,
  // a period is the difference of timestamps, loss is elapsed time reaching the counter limit.
  int       cyc = 0;
  bit       m_on = 0;
  bit [2:0] dq;
  bit       prev;
  int       cmax [2] = '{65535, 255};
  bit       acq [2], nr [2], fv [2], lk [2];
  int       last [2], fp [2], lc [2], acc [2];

  always @(posedge clk) begin : model
    bit ev;
    int p, c, d;
    cyc++;
    if (rst) begin
      m_on = 1;
      dq   = '0;
      prev = 0;
      for (int i = 0; i < 2; i++) begin
        acq[i] = 1; nr[i] = 1; fv[i] = 0; lk[i] = 0; lc[i] = 0; fp[i] = DEF; acc[i] = 0;
      end
    end else begin
      ev    = dq[2];
      dq    = {dq[1:0], rin & ~prev};
      prev  = rin;
      for (int i = 0; i < 2; i++) begin
        fv[i] = 0;
        if (acq[i]) begin
          if (ev) begin
            acq[i]  = 0;
            last[i] = cyc;
          end
        end else if (ev) begin
          p       = cyc - last[i];
          last[i] = cyc;
          c       = (p > 255) ? 255 : p;
          fv[i]   = 1;
          if (nr[i]) begin
            nr[i] = 0;
            lc[i] = 0;
            acc[i] = c << K;
          end else begin
            d = (c > fp[i]) ? c - fp[i] : fp[i] - c;
            if (d <= TOL) begin
              if (lc[i] < LCNT) lc[i]++;
              if (lc[i] == LCNT) lk[i] = 1;
            end else begin
              lc[i] = 0;
              lk[i] = 0;
            end
            acc[i] = acc[i] + c - (acc[i] >> K);
          end
`ifdef PERIOD_FILTER_EN
          fp[i] = acc[i] >> K;
`else
          fp[i] = c;
`endif
        end else if (cyc - last[i] == cmax[i]) begin
          acq[i] = 1; nr[i] = 1; lk[i] = 0; lc[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("fp_long",     fp_l, fp[0]);
      chk("valid_long",  fv_l, fv[0]);
      chk("locked_long", lk_l, lk[0]);
      chk("noref_long",  nr_l, nr[0]);
      chk("fp_short",    fp_s, fp[1]);
      chk("valid_short", fv_s, fv[1]);
      chk("locked_short",lk_s, lk[1]);
      chk("noref_short", nr_s, nr[1]);
    end
  end

  task automatic ref_pulse(input int per, input int hi);
    rin = 1'b1;
    repeat (hi) @(negedge clk);
    rin = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  int per, reps, pj;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_fp",    fp_l, DEF);
    chk("idle_noref", nr_l, 1);

    // Steady period 50: locks after the fifth measurement.
    repeat (11) ref_pulse(50, 25);
    chk("p50_fp",     fp_l, 50);
    chk("p50_locked", lk_l, 1);
    chk("p50_noref",  nr_l, 0);

    // Period 400 clamps to 255 on the wide counter; the 8-bit counter keeps timing out.
    repeat (8) ref_pulse(400, 100);
`ifndef PERIOD_FILTER_EN
    chk("p400_fp",     fp_l, 255);
    chk("p400_locked", lk_l, 1);
`endif
    chk("p400_short_noref", nr_s, 1);

    // Lock both at 100, then stop the reference.
    repeat (8) ref_pulse(100, 50);
    chk("p100_short_locked", lk_s, 1);
    repeat (300) @(negedge clk);
    chk("loss_short_noref",  nr_s, 1);
    chk("loss_short_locked", lk_s, 0);
    chk("loss_short_fp",     fp_s, 100);
    chk("loss_long_locked",  lk_l, 1);

    // Mid-period reset while locked.
    repeat (8) ref_pulse(30, 15);
    repeat (7) @(negedge clk);
    chk("pre_rst_locked", lk_l, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_fp",     fp_l, DEF);
    chk("rst_locked", lk_l, 0);
    chk("rst_noref",  nr_l, 1);
    chk("rst_valid",  fv_l, 0);
    repeat (8) ref_pulse(30, 15);

    // Saturation boundary on the 8-bit counter: 255 is measured, 256 times out.
    repeat (4) ref_pulse(255, 100);
    repeat (4) ref_pulse(256, 100);

    // Random periods with jitter and occasional resets.
    for (int s = 0; s < 30; s++) begin
      per  = int'($urandom_range(4, 300));
      reps = int'($urandom_range(1, 5));
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
      for (int r = 0; r < reps; r++) begin
        pj = per + int'($urandom_range(0, 4)) - 2;
        if (pj < 4) pj = 4;
        ref_pulse(pj, int'($urandom_range(1, pj - 1)));
      end
    end
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
